// File: rtl/csa_pkg.sv
// csa_pkg: shared widths, operand/result types and majority helper for the carry-save datapath
package csa_pkg;
  localparam int CSA_W = 16;
  typedef logic [CSA_W-1:0] csa_op_t;
  typedef logic [CSA_W+1:0] csa_res_t;
  function automatic csa_res_t maj3(input csa_res_t a, input csa_res_t b, input csa_res_t c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: combinational 3:2 compressor row (a,b,c -> sum s, unshifted carry cy)
module csa_row
  import csa_pkg::*;
(
  input  csa_res_t a,
  input  csa_res_t b,
  input  csa_res_t c,
  output csa_res_t s,
  output csa_res_t cy
);
  assign s  = a ^ b ^ c;
  assign cy = maj3(a, b, c);
endmodule

// File: rtl/csa_sub_16.sv
// csa_sub_16: 2-stage elastic x-y-z subtractor (CSA of x,~y,~z + CPA); CSA_SUB_SAT_EN clamps negatives to 0
module csa_sub_16
  import csa_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CSA_W-1:0]   x,
  input  logic [CSA_W-1:0]   y,
  input  logic [CSA_W-1:0]   z,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CSA_W+1:0]   diff,
  output logic               neg,
  output logic               sat
);
  csa_res_t s, cy, s1_s, s1_c, sum, diff_d;
  logic s1_valid, adv1, adv2, sat_d;
  csa_row u_row (
    .a  (csa_res_t'(x)),
    .b  (~csa_res_t'(y)),
    .c  (~csa_res_t'(z)),
    .s  (s),
    .cy (cy)
  );
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = rst_n && adv1;
  // the shifted carry brings the first +1 in bit0, the literal 1 is the second
  assign sum = s1_s + s1_c + csa_res_t'(1);
`ifdef CSA_SUB_SAT_EN
  assign sat_d = sum[CSA_W+1];
`else
  assign sat_d = 1'b0;
`endif
  assign diff_d = sat_d ? '0 : sum;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_s      <= '0;
      s1_c      <= '0;
      out_valid <= 1'b0;
      diff      <= '0;
      neg       <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_s <= s;
          s1_c <= (cy << 1) | csa_res_t'(1);
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          diff <= diff_d;
          neg  <= sum[CSA_W+1];
          sat  <= sat_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_csa_sub_16.sv
// tb_csa_sub_16: directed table, backpressure, reset and random scoreboard checks for csa_sub_16
module tb_csa_sub_16;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, neg, sat;
  logic [15:0] x = 0, y = 0, z = 0;
  logic [17:0] diff;
  int checks = 0, errors = 0;

  typedef struct {logic [17:0] d; logic n; logic s;} res_t;
  typedef struct {logic [15:0] x, y, z; logic [17:0] d; logic n; logic s;} vec_t;
  res_t q[$];
  vec_t tbl[5];
  logic stalled = 0;
  logic [17:0] held;

  csa_sub_16 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .z(z), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .neg(neg), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    res_t r;
    int d;
    d = int'(a) - int'(b) - int'(c);
    r.n = d < 0;
    r.d = 18'(d);
    r.s = 1'b0;
`ifdef CSA_SUB_SAT_EN
    if (d < 0) begin
      r.d = '0;
      r.s = 1'b1;
    end
`endif
    return r;
  endfunction

  // scoreboard: transfers seen at the negedge happen at the following posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stalled = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 32'(diff), 32'hFFFFFFFF);
        end else begin
          res_t e;
          e = q.pop_front();
          chk("sb_diff", 32'(diff), 32'(e.d));
          chk("sb_neg", 32'(neg), 32'(e.n));
          chk("sb_sat", 32'(sat), 32'(e.s));
        end
      end
      if (stalled && out_valid) chk("stall_hold", 32'(diff), 32'(held));
      if (in_valid && in_ready) q.push_back(model(x, y, z));
      stalled = out_valid && !out_ready;
      held = diff;
    end
  end

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1; x = v.x; y = v.y; z = v.z; out_ready = 1;
    @(negedge clk);
    chk("vec_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    chk("vec_lat1_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("vec_lat2_valid", 32'(out_valid), 1);
    chk("vec_diff", 32'(diff), 32'(v.d));
    chk("vec_neg", 32'(neg), 32'(v.n));
    chk("vec_sat", 32'(sat), 32'(v.s));
  endtask

  initial begin
    int sent, outs, i;
    logic fire;
    logic [17:0] hold_d;
    tbl[0] = '{16'd100, 16'd20, 16'd30, 18'd50, 1'b0, 1'b0};
`ifdef CSA_SUB_SAT_EN
    tbl[1] = '{16'd0, 16'd1, 16'd1, 18'h00000, 1'b1, 1'b1};
    tbl[3] = '{16'd0, 16'hFFFF, 16'hFFFF, 18'h00000, 1'b1, 1'b1};
`else
    tbl[1] = '{16'd0, 16'd1, 16'd1, 18'h3FFFE, 1'b1, 1'b0};
    tbl[3] = '{16'd0, 16'hFFFF, 16'hFFFF, 18'h20002, 1'b1, 1'b0};
`endif
    tbl[2] = '{16'hFFFF, 16'd0, 16'd0, 18'h0FFFF, 1'b0, 1'b0};
    tbl[4] = '{16'd500, 16'd200, 16'd300, 18'h00000, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_neg", 32'(neg), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 rst_n = 1;

    for (int k = 0; k < 5; k++) run_vec(tbl[k]);

    // backpressure: 8 back-to-back sets, out_ready low for 5 cycles
    @(posedge clk); #1;
    out_ready = 0; sent = 0; outs = 0;
    in_valid = 1; x = 16'd1000; y = 16'd1; z = 16'd0;
    hold_d = '0;
    for (int c = 0; c < 40 && outs < 8; c++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      if (c == 2) hold_d = diff;
      if (c == 3 || c == 4) chk("bp_hold", 32'(diff), 32'(hold_d));
      if (c == 4) begin
        chk("bp_accepts", 32'(sent), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
      end
      if (out_ready && outs > 0 && outs < 8 && !out_valid) chk("bp_gap", 32'(out_valid), 1);
      if (out_valid && out_ready) outs++;
      @(posedge clk); #1;
      if (fire) begin
        sent++;
        if (sent < 8) begin
          x = 16'(1000 + sent * 37); y = 16'(sent); z = 16'(sent * 3);
        end else in_valid = 0;
      end
      if (c == 4) out_ready = 1;
    end
    chk("bp_outs", 32'(outs), 8);

    // reset with both stages full
    out_ready = 0;
    in_valid = 1; x = 16'd7; y = 16'd1; z = 16'd1;
    for (i = 0; i < 10 && sent < 10; i++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) sent++;
    end
    in_valid = 0;
    @(negedge clk);
    chk("pre_rst_full", 32'(out_valid && !in_ready), 1);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("rst_cycle_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 rst_n = 1; out_ready = 1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 0);
    chk("post_rst_diff", 32'(diff), 0);
    repeat (4) @(negedge clk);
    chk("post_rst_quiet", 32'(out_valid), 0);

    // random traffic against the scoreboard
    sent = 0; fire = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      @(posedge clk); #1;
      if (fire) sent++;
      if (!in_valid || fire) begin
        in_valid = sent < 10000 && $urandom_range(0, 3) != 0;
        x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
        if ($urandom_range(0, 7) == 0) x = 16'hFFFF;
        if ($urandom_range(0, 7) == 0) begin y = 16'hFFFF; z = 16'hFFFF; end
      end
      out_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      fire = in_valid && in_ready;
    end
    chk("rand_sent", 32'(sent), 10000);
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 20 && q.size() > 0; c++) @(negedge clk);
    chk("rand_drained", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
